// File: rtl/casez_match_table.sv
// Registered, programmable casez engine. Each row holds a label with per-bit wildcards.
// Lookups take two cycles: stage 1 captures the row matches, stage 2 picks the lowest hit.

module casez_match_row #(
  parameter int WIDTH    = 3,
  parameter int RESULT_W = 3,
  parameter int IDX_W    = 2,
  parameter int ROW      = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [WIDTH-1:0]    wr_pattern,
  input  logic [WIDTH-1:0]    wr_mask,
  input  logic [RESULT_W-1:0] wr_result,
  input  logic                wr_enable,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [WIDTH-1:0]    in_zmask,
  output logic                match,
  output logic [RESULT_W-1:0] result
);
  logic             vld;
  logic [WIDTH-1:0] pat, msk;

  // Out-of-range indices never equal any ROW, so those writes fall on the floor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld    <= 1'b0;
      pat    <= '0;
      msk    <= '0;
      result <= '0;
    end else if (wr_en && wr_idx == IDX_W'(ROW)) begin
      vld    <= wr_enable;
      pat    <= wr_pattern;
      msk    <= wr_mask;
      result <= wr_result;
    end
  end

  // A bit is compared only when neither the label nor the expression wildcards it.
  assign match = vld && (((in_data ^ pat) & ~msk & ~in_zmask) == '0);
endmodule

module casez_match_table #(
  parameter int WIDTH    = 3,
  parameter int ENTRIES  = 4,
  parameter int RESULT_W = 3,
  parameter int CNT_W    = 16,
  localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [WIDTH-1:0]    wr_pattern,
  input  logic [WIDTH-1:0]    wr_mask,
  input  logic [RESULT_W-1:0] wr_result,
  input  logic                wr_enable,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [WIDTH-1:0]    in_zmask,
  output logic                out_valid,
  output logic                out_hit,
  output logic [IDX_W-1:0]    out_idx,
  output logic [RESULT_W-1:0] result,
  output logic [CNT_W-1:0]    miss_count,
  input  logic                miss_clr
);
  localparam int LAT = 2;

  typedef struct packed {
    logic                hit;
    logic [IDX_W-1:0]    idx;
    logic [RESULT_W-1:0] res;
  } win_t;

  logic [ENTRIES-1:0]               row_match, s1_match;
  logic [ENTRIES-1:0][RESULT_W-1:0] row_res, s1_res;
  logic [LAT-1:0]                   vld_pipe;
  win_t                             win;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_row
    casez_match_row #(
      .WIDTH(WIDTH), .RESULT_W(RESULT_W), .IDX_W(IDX_W), .ROW(g)
    ) u_row (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_pattern (wr_pattern),
      .wr_mask    (wr_mask),
      .wr_result  (wr_result),
      .wr_enable  (wr_enable),
      .in_data    (in_data),
      .in_zmask   (in_zmask),
      .match      (row_match[g]),
      .result     (row_res[g])
    );
  end

  // Results are snapshotted with the matches so a write landing while a lookup is
  // in stage 2 cannot mix old match bits with new row contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      s1_match <= '0;
      s1_res   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LAT-2:0], in_valid};
      if (in_valid) begin
        s1_match <= row_match;
        s1_res   <= row_res;
      end
    end
  end

  // Scan high to low so the lowest matching row is the one left standing.
  always_comb begin
    win = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (s1_match[i]) begin
        win.hit = 1'b1;
        win.idx = IDX_W'(i);
        win.res = s1_res[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_hit <= 1'b0;
      out_idx <= '0;
      result  <= '0;
    end else if (vld_pipe[0]) begin
      out_hit <= win.hit;
      out_idx <= win.idx;
      if (win.hit) result <= win.res;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      miss_count <= '0;
    else if (miss_clr)
      miss_count <= '0;
    else if (vld_pipe[0] && !win.hit && miss_count != '1)
      miss_count <= miss_count + 1'b1;
  end

  assign out_valid = vld_pipe[LAT-1];
endmodule

// File: tb/tb_casez_match_table.sv
// Bench for casez_match_table: table of lookups plus hand sequences, scoreboard queue
// filled at issue and drained when out_valid appears.

module tb_casez_match_table;
  localparam int WIDTH = 3, ENTRIES = 4, RESULT_W = 3, CNT_W = 16, IDX_W = 2;

  logic                clk = 1'b0, reset = 1'b1;
  logic                wr_en = 1'b0, wr_enable = 1'b0;
  logic [IDX_W-1:0]    wr_idx = '0;
  logic [WIDTH-1:0]    wr_pattern = '0, wr_mask = '0;
  logic [RESULT_W-1:0] wr_result = '0;
  logic                in_valid = 1'b0, miss_clr = 1'b0;
  logic [WIDTH-1:0]    in_data = '0, in_zmask = '0;
  logic                out_valid, out_hit;
  logic [IDX_W-1:0]    out_idx;
  logic [RESULT_W-1:0] result;
  logic [CNT_W-1:0]    miss_count;

  casez_match_table #(.WIDTH(WIDTH), .ENTRIES(ENTRIES), .RESULT_W(RESULT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_pattern(wr_pattern),
    .wr_mask(wr_mask), .wr_result(wr_result), .wr_enable(wr_enable), .in_valid(in_valid),
    .in_data(in_data), .in_zmask(in_zmask), .out_valid(out_valid), .out_hit(out_hit),
    .out_idx(out_idx), .result(result), .miss_count(miss_count), .miss_clr(miss_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                hit;
    logic [IDX_W-1:0]    idx;
    logic [RESULT_W-1:0] res;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] zm;
    exp_t             e;
  } vec_t;

  exp_t q[$];
  exp_t mon_e;
  int   ov_cyc[$];
  int   checks = 0, errors = 0, cyc = 0;
  vec_t tbl[3];

  function automatic vec_t mk(logic [2:0] d, logic [2:0] z, logic h, logic [1:0] i, logic [2:0] r);
    vec_t v;
    v.data = d; v.zm = z; v.e.hit = h; v.e.idx = i; v.e.res = r;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (out_valid) begin
      ov_cyc.push_back(cyc);
      if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("out_hit", int'(out_hit), int'(mon_e.hit));
        chk("out_idx", int'(out_idx), int'(mon_e.idx));
        chk("result", int'(result), int'(mon_e.res));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] i, input logic [2:0] p, input logic [2:0] m,
                    input logic [2:0] r, input logic en);
    wr_en = 1'b1; wr_idx = i; wr_pattern = p; wr_mask = m; wr_result = r; wr_enable = en;
    step();
    wr_en = 1'b0;
  endtask

  task automatic look(input vec_t v);
    in_valid = 1'b1; in_data = v.data; in_zmask = v.zm;
    q.push_back(v.e);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) step();
  endtask

  initial begin
    // reset state
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_hit", int'(out_hit), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_miss_count", int'(miss_count), 0);

    // reset while lookups are in flight drops them
    in_valid = 1'b1; in_data = 3'b000; in_zmask = '0;
    step(); step();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    step(); step();
    chk("midrst_hold_valid", int'(out_valid), 0);
    chk("midrst_miss_count", int'(miss_count), 0);
    reset = 1'b0;
    drain();
    chk("postrst_miss_count", int'(miss_count), 0);
    chk("postrst_out_hit", int'(out_hit), 0);

    // rows 000->0, 010->1, 110->2; row 3 stays invalid
    wr(2'd0, 3'b000, 3'b000, 3'd0, 1'b1);
    wr(2'd1, 3'b010, 3'b000, 3'd1, 1'b1);
    wr(2'd2, 3'b110, 3'b000, 3'd2, 1'b1);

    tbl[0] = mk(3'b000, 3'b010, 1'b1, 2'd0, 3'd0);
    tbl[1] = mk(3'b010, 3'b001, 1'b1, 2'd1, 3'd1);
    tbl[2] = mk(3'b111, 3'b000, 1'b0, 2'd0, 3'd1);
    foreach (tbl[i]) begin
      look(tbl[i]);
      drain();
    end
    chk("miss_count_after_table", int'(miss_count), 1);

    // miss in stage 2 coincident with miss_clr: clear wins
    in_valid = 1'b1; in_data = 3'b111; in_zmask = '0;
    q.push_back('{hit: 1'b0, idx: 2'd0, res: 3'd1});
    step();
    in_valid = 1'b0; miss_clr = 1'b1;
    step();
    miss_clr = 1'b0;
    chk("miss_clr_wins", int'(miss_count), 0);
    drain();
    chk("miss_clr_stays", int'(miss_count), 0);

    // back-to-back lookups; row1 rewritten in the same cycle as the 111 lookup
    ov_cyc.delete();
    in_valid = 1'b1; in_data = 3'b000; in_zmask = '0;
    q.push_back('{hit: 1'b1, idx: 2'd0, res: 3'd0});
    step();
    in_data = 3'b110;
    q.push_back('{hit: 1'b1, idx: 2'd2, res: 3'd2});
    step();
    in_data = 3'b111;
    q.push_back('{hit: 1'b0, idx: 2'd0, res: 3'd2});
    wr_en = 1'b1; wr_idx = 2'd1; wr_pattern = 3'b111; wr_mask = '0; wr_result = 3'd5; wr_enable = 1'b1;
    step();
    in_valid = 1'b0; wr_en = 1'b0;
    drain();
    chk("burst_out_valid_count", ov_cyc.size(), 3);
    if (ov_cyc.size() == 3) chk("burst_consecutive", ov_cyc[2] - ov_cyc[0], 2);
    look(mk(3'b111, 3'b000, 1'b1, 2'd1, 3'd5));
    drain();
    chk("miss_count_after_burst", int'(miss_count), 1);

    // priority: catch-all row 0 shadows row 1 until disabled
    wr(2'd0, 3'b000, 3'b111, 3'd7, 1'b1);
    wr(2'd1, 3'b010, 3'b000, 3'd1, 1'b1);
    look(mk(3'b010, 3'b000, 1'b1, 2'd0, 3'd7));
    drain();
    wr(2'd0, 3'b000, 3'b111, 3'd7, 1'b0);
    look(mk(3'b010, 3'b000, 1'b1, 2'd1, 3'd1));
    look(mk(3'b101, 3'b111, 1'b1, 2'd1, 3'd1));
    look(mk(3'b110, 3'b000, 1'b1, 2'd2, 3'd2));
    look(mk(3'b011, 3'b000, 1'b0, 2'd0, 3'd2));
    drain();
    chk("miss_count_final", int'(miss_count), 2);

    for (int n = 0; n < 20 && q.size() != 0; n++) step();
    chk("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
